bout_referee: RTL and testbench

Match controller for the boxing game. Watches the 2-bit state outputs of both `player` instances, turns each new punch into a hit or a block, and keeps hit points and a round timer. It detects knock-out or time-out and declares the winner. It also gates both players through `fight_en`, which the top level ANDs into each player's active-low reset.

---
 rtl/boxing_pkg.sv | 40 ++++
 rtl/punch_edge.sv | 24 ++
 rtl/bout_referee.sv | 170 +++++++++++++++++
 tb/tb_bout_referee.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/boxing_pkg.sv
// Shared codes for the boxing game: player states, match phases, winner codes,
// plus the small arithmetic helpers the referee uses.
package boxing_pkg;

    typedef enum logic [1:0] {
        ST_NONE  = 2'b00,
        ST_DEF   = 2'b01,
        ST_ATK   = 2'b10,
        ST_PUNCH = 2'b11
    } pstate_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'b00,
        PH_COUNT = 2'b01,
        PH_FIGHT = 2'b10,
        PH_OVER  = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    function automatic winner_t hp_compare(input logic [2:0] hp1, input logic [2:0] hp2);
        if (hp1 > hp2) begin
            return WIN_P1;
        end else if (hp2 > hp1) begin
            return WIN_P2;
        end else begin
            return WIN_DRAW;
        end
    endfunction

endpackage

// File: rtl/punch_edge.sv
// Detects the rising edge into the punching state for one player.
module punch_edge
    import boxing_pkg::*;
(
    input  logic       clk_act,
    input  logic       rst,
    input  logic [1:0] state,
    output logic       evt
);

    logic [1:0] prev_r;

    // Previous player state, tracked in every phase so a held punch never re-fires.
    always_ff @(posedge clk_act) begin
        if (!rst) begin
            prev_r <= ST_NONE;
        end else begin
            prev_r <= state;
        end
    end

    assign evt = (state == ST_PUNCH) && (prev_r != ST_PUNCH);

endmodule

// File: rtl/bout_referee.sv
// Match controller: countdown, punch resolution, hit points, round timer and winner.
module bout_referee
    import boxing_pkg::*;
#(
    parameter int HP_MAX    = 5,
    parameter int ROUND_SEC = 60,
    parameter int TICK_DIV  = 1000,
    parameter int COUNT_CYC = 3000
) (
    input  logic       clk_act,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] p1_state,
    input  logic [1:0] p2_state,
    output logic       fight_en,
    output logic [1:0] phase,
    output logic [2:0] p1_hp,
    output logic [2:0] p2_hp,
    output logic [6:0] time_left,
    output logic       hit1,
    output logic       hit2,
    output logic       blk1,
    output logic       blk2,
    output logic [1:0] winner
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (COUNT_CYC > 1) ? $clog2(COUNT_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_CYC - 1);
    localparam logic [2:0]    HP_INIT    = 3'(HP_MAX);
    localparam logic [6:0]    TIME_INIT  = 7'(ROUND_SEC);

    phase_t        phase_r;
    winner_t       winner_r;
    logic          fight_en_r;
    logic [2:0]    p1_hp_r, p2_hp_r;
    logic [6:0]    time_left_r;
    logic [TW-1:0] tick_r;
    logic [CW-1:0] cnt_r;
    logic          hit1_r, hit2_r, blk1_r, blk2_r;

    logic          evt1_s, evt2_s;
    logic          hit1_s, hit2_s, blk1_s, blk2_s;
    logic [2:0]    p1_hp_nx_s, p2_hp_nx_s;
    logic          end_s;

    punch_edge u_edge1 (.clk_act(clk_act), .rst(rst), .state(p1_state), .evt(evt1_s));
    punch_edge u_edge2 (.clk_act(clk_act), .rst(rst), .state(p2_state), .evt(evt2_s));

    // Resolve each player's punch independently: blocked if the opponent defends, else a hit.
    always_comb begin
        hit1_s     = 1'b0;
        hit2_s     = 1'b0;
        blk1_s     = 1'b0;
        blk2_s     = 1'b0;
        p1_hp_nx_s = p1_hp_r;
        p2_hp_nx_s = p2_hp_r;
        if ((phase_r == PH_FIGHT) && evt1_s) begin
            if (p2_state == ST_DEF) begin
                blk2_s = 1'b1;
            end else begin
                hit1_s     = 1'b1;
                p2_hp_nx_s = sat_dec(p2_hp_r);
            end
        end else begin
            blk2_s = 1'b0;
        end
        if ((phase_r == PH_FIGHT) && evt2_s) begin
            if (p1_state == ST_DEF) begin
                blk1_s = 1'b1;
            end else begin
                hit2_s     = 1'b1;
                p1_hp_nx_s = sat_dec(p1_hp_r);
            end
        end else begin
            blk1_s = 1'b0;
        end
    end

    assign end_s = (p1_hp_r == 3'd0) || (p2_hp_r == 3'd0) || (time_left_r == 7'd0);

    // Match FSM with timer and HP registers; the exit edge out of FIGHT is still a full fight cycle.
    always_ff @(posedge clk_act) begin
        if (!rst) begin
            phase_r     <= PH_IDLE;
            fight_en_r  <= 1'b0;
            p1_hp_r     <= HP_INIT;
            p2_hp_r     <= HP_INIT;
            time_left_r <= TIME_INIT;
            winner_r    <= WIN_NONE;
            tick_r      <= '0;
            cnt_r       <= '0;
            hit1_r      <= 1'b0;
            hit2_r      <= 1'b0;
            blk1_r      <= 1'b0;
            blk2_r      <= 1'b0;
        end else begin
            hit1_r <= 1'b0;
            hit2_r <= 1'b0;
            blk1_r <= 1'b0;
            blk2_r <= 1'b0;
            case (phase_r)
                PH_IDLE, PH_OVER: begin
                    if (start) begin
                        phase_r     <= PH_COUNT;
                        p1_hp_r     <= HP_INIT;
                        p2_hp_r     <= HP_INIT;
                        time_left_r <= TIME_INIT;
                        winner_r    <= WIN_NONE;
                        tick_r      <= '0;
                        cnt_r       <= '0;
                    end else begin
                        phase_r <= phase_r;
                    end
                end
                PH_COUNT: begin
                    if (cnt_r == COUNT_LAST) begin
                        phase_r    <= PH_FIGHT;
                        fight_en_r <= 1'b1;
                        cnt_r      <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                PH_FIGHT: begin
                    hit1_r  <= hit1_s;
                    hit2_r  <= hit2_s;
                    blk1_r  <= blk1_s;
                    blk2_r  <= blk2_s;
                    p1_hp_r <= p1_hp_nx_s;
                    p2_hp_r <= p2_hp_nx_s;
                    if (tick_r == TICK_LAST) begin
                        tick_r <= '0;
                        if (time_left_r != 7'd0) begin
                            time_left_r <= time_left_r - 7'd1;
                        end else begin
                            time_left_r <= 7'd0;
                        end
                    end else begin
                        tick_r <= tick_r + TW'(1);
                    end
                    if (end_s) begin
                        phase_r    <= PH_OVER;
                        fight_en_r <= 1'b0;
                        winner_r   <= hp_compare(p1_hp_nx_s, p2_hp_nx_s);
                    end else begin
                        phase_r <= PH_FIGHT;
                    end
                end
                default: begin
                    phase_r    <= PH_IDLE;
                    fight_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign fight_en  = fight_en_r;
    assign phase     = phase_r;
    assign p1_hp     = p1_hp_r;
    assign p2_hp     = p2_hp_r;
    assign time_left = time_left_r;
    assign hit1      = hit1_r;
    assign hit2      = hit2_r;
    assign blk1      = blk1_r;
    assign blk2      = blk2_r;
    assign winner    = winner_r;

endmodule

// File: tb/tb_bout_referee.sv
// Directed bench for bout_referee: two parameterisations checked every cycle
// against an elapsed-time behavioural model, plus hand-computed spot checks.
module tb_bout_referee;

    logic clk_act = 1'b0;
    always #5 clk_act = ~clk_act;

    logic       rst_v   [2];
    logic       start_v [2];
    logic [1:0] p1_v    [2];
    logic [1:0] p2_v    [2];

    logic       fen_o   [2];
    logic [1:0] phase_o [2];
    logic [2:0] hp1_o   [2];
    logic [2:0] hp2_o   [2];
    logic [6:0] tl_o    [2];
    logic       hit1_o  [2];
    logic       hit2_o  [2];
    logic       blk1_o  [2];
    logic       blk2_o  [2];
    logic [1:0] win_o   [2];

    bout_referee #(.HP_MAX(5), .ROUND_SEC(60), .TICK_DIV(1000), .COUNT_CYC(4)) dut_a (
        .clk_act(clk_act), .rst(rst_v[0]), .start(start_v[0]),
        .p1_state(p1_v[0]), .p2_state(p2_v[0]), .fight_en(fen_o[0]), .phase(phase_o[0]),
        .p1_hp(hp1_o[0]), .p2_hp(hp2_o[0]), .time_left(tl_o[0]),
        .hit1(hit1_o[0]), .hit2(hit2_o[0]), .blk1(blk1_o[0]), .blk2(blk2_o[0]), .winner(win_o[0]));

    bout_referee #(.HP_MAX(5), .ROUND_SEC(3), .TICK_DIV(2), .COUNT_CYC(4)) dut_b (
        .clk_act(clk_act), .rst(rst_v[1]), .start(start_v[1]),
        .p1_state(p1_v[1]), .p2_state(p2_v[1]), .fight_en(fen_o[1]), .phase(phase_o[1]),
        .p1_hp(hp1_o[1]), .p2_hp(hp2_o[1]), .time_left(tl_o[1]),
        .hit1(hit1_o[1]), .hit2(hit2_o[1]), .blk1(blk1_o[1]), .blk2(blk2_o[1]), .winner(win_o[1]));

    int checks   = 0;
    int failures = 0;

    int c_hp    [2] = '{5, 5};
    int c_round [2] = '{60, 3};
    int c_tick  [2] = '{1000, 2};
    int c_count [2] = '{4, 4};

    int m_valid [2] = '{0, 0};
    int m_phase [2];
    int m_cnt   [2];
    int m_el    [2];
    int m_hp1   [2];
    int m_hp2   [2];
    int m_prev1 [2];
    int m_prev2 [2];
    int m_h1    [2];
    int m_h2    [2];
    int m_b1    [2];
    int m_b2    [2];
    int m_win   [2];

    function automatic void chk(string nm, int k, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endfunction

    // time left is the round length minus whole time units elapsed in FIGHT
    function automatic int m_tl(int k);
        int t;
        t = c_round[k] - m_el[k] / c_tick[k];
        return (t < 0) ? 0 : t;
    endfunction

    task automatic m_step(int k);
        int p1, p2;
        bit ev1, ev2, over;
        p1  = int'(p1_v[k]);
        p2  = int'(p2_v[k]);
        ev1 = (p1 == 3) && (m_prev1[k] != 3);
        ev2 = (p2 == 3) && (m_prev2[k] != 3);
        if (rst_v[k] === 1'b0) begin
            m_valid[k] = 1;
            m_phase[k] = 0; m_cnt[k] = 0; m_el[k] = 0;
            m_hp1[k] = c_hp[k]; m_hp2[k] = c_hp[k]; m_win[k] = 0;
            m_h1[k] = 0; m_h2[k] = 0; m_b1[k] = 0; m_b2[k] = 0;
        end else if (m_valid[k] != 0) begin
            m_h1[k] = 0; m_h2[k] = 0; m_b1[k] = 0; m_b2[k] = 0;
            case (m_phase[k])
                0, 3: begin
                    if (start_v[k] === 1'b1) begin
                        m_phase[k] = 1; m_cnt[k] = 0; m_el[k] = 0;
                        m_hp1[k] = c_hp[k]; m_hp2[k] = c_hp[k]; m_win[k] = 0;
                    end
                end
                1: begin
                    m_cnt[k]++;
                    if (m_cnt[k] == c_count[k]) m_phase[k] = 2;
                end
                default: begin
                    over = (m_hp1[k] == 0) || (m_hp2[k] == 0) || (m_tl(k) == 0);
                    if (ev1) begin
                        if (p2 == 1) m_b2[k] = 1;
                        else begin m_h1[k] = 1; if (m_hp2[k] > 0) m_hp2[k]--; end
                    end
                    if (ev2) begin
                        if (p1 == 1) m_b1[k] = 1;
                        else begin m_h2[k] = 1; if (m_hp1[k] > 0) m_hp1[k]--; end
                    end
                    m_el[k]++;
                    if (over) begin
                        m_phase[k] = 3;
                        m_win[k] = (m_hp1[k] > m_hp2[k]) ? 1 : (m_hp2[k] > m_hp1[k]) ? 2 : 3;
                    end
                end
            endcase
        end
        m_prev1[k] = p1;
        m_prev2[k] = p2;
    endtask

    // Compare on the falling edge, then advance the model by the inputs the next rising edge will see.
    initial begin
        forever begin
            @(negedge clk_act);
            for (int k = 0; k < 2; k++) begin
                if (m_valid[k] != 0) begin
                    chk("phase", k, int'(phase_o[k]), m_phase[k]);
                    chk("fight_en", k, int'(fen_o[k]), (m_phase[k] == 2) ? 1 : 0);
                    chk("p1_hp", k, int'(hp1_o[k]), m_hp1[k]);
                    chk("p2_hp", k, int'(hp2_o[k]), m_hp2[k]);
                    chk("time_left", k, int'(tl_o[k]), m_tl(k));
                    chk("hit1", k, int'(hit1_o[k]), m_h1[k]);
                    chk("hit2", k, int'(hit2_o[k]), m_h2[k]);
                    chk("blk1", k, int'(blk1_o[k]), m_b1[k]);
                    chk("blk2", k, int'(blk2_o[k]), m_b2[k]);
                    chk("winner", k, int'(win_o[k]), m_win[k]);
                end
                m_step(k);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk_act);
            #1;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b0; start_v[k] = 1'b0; p1_v[k] = 2'b00; p2_v[k] = 2'b00;
        end
        step(2);
        chk("rst_phase", 0, int'(phase_o[0]), 0);
        chk("rst_hp", 0, int'(hp1_o[0]) * 10 + int'(hp2_o[0]), 55);
        chk("rst_time", 0, int'(tl_o[0]), 60);
        chk("rst_win_fen", 0, int'(win_o[0]) * 2 + int'(fen_o[0]), 0);
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;

        start_v[0] = 1'b1; step(1);
        chk("count_entry", 0, int'(phase_o[0]), 1);
        start_v[0] = 1'b0; step(3);
        chk("count_hold", 0, int'(phase_o[0]), 1);
        step(1);
        chk("fight_entry", 0, int'(phase_o[0]) * 10 + int'(fen_o[0]), 21);
        chk("fight_hp", 0, int'(hp1_o[0]) * 10 + int'(hp2_o[0]), 55);
        chk("fight_time", 0, int'(tl_o[0]), 60);

        p1_v[0] = 2'b10; step(1);
        p1_v[0] = 2'b11; step(1);
        chk("hit1_pulse", 0, int'(hit1_o[0]) * 10 + int'(hp2_o[0]), 14);
        step(1);
        chk("hit1_width", 0, int'(hit1_o[0]), 0);
        step(9);
        chk("held_no_rehit", 0, int'(hp2_o[0]), 4);

        p1_v[0] = 2'b00; step(1);
        p1_v[0] = 2'b11; p2_v[0] = 2'b01; step(1);
        chk("block", 0, int'(blk2_o[0]) * 100 + int'(hit1_o[0]) * 10 + int'(hp2_o[0]), 104);
        p1_v[0] = 2'b00; p2_v[0] = 2'b00; step(1);
        chk("block_width", 0, int'(blk2_o[0]), 0);

        p1_v[0] = 2'b11; p2_v[0] = 2'b11; step(1);
        chk("double_hit", 0, int'(hit1_o[0]) * 10 + int'(hit2_o[0]), 11);
        chk("double_hp", 0, int'(hp1_o[0]) * 10 + int'(hp2_o[0]), 43);
        p1_v[0] = 2'b00; p2_v[0] = 2'b00; step(1);

        for (int i = 0; i < 3; i++) begin
            p1_v[0] = 2'b11; step(1);
            if (i == 2) chk("ko_still_fight", 0, int'(phase_o[0]) * 10 + int'(hp2_o[0]), 20);
            p1_v[0] = 2'b00; step(1);
        end
        chk("ko_over", 0, int'(phase_o[0]) * 100 + int'(win_o[0]) * 10 + int'(fen_o[0]), 310);
        p1_v[0] = 2'b11; step(1);
        chk("over_no_pulse", 0, int'(hit1_o[0]) * 10 + int'(phase_o[0]), 3);
        p1_v[0] = 2'b00; step(1);

        start_v[0] = 1'b1; step(1);
        chk("restart", 0, int'(phase_o[0]) * 1000 + int'(hp1_o[0]) * 100 + int'(hp2_o[0]) * 10 + int'(win_o[0]), 1550);
        start_v[0] = 1'b0; step(4);
        chk("refight", 0, int'(phase_o[0]), 2);
        for (int i = 0; i < 3; i++) begin
            p2_v[0] = 2'b11; step(1);
            p2_v[0] = 2'b00; step(1);
        end
        chk("p1_hp_two", 0, int'(hp1_o[0]) * 10 + int'(phase_o[0]), 22);
        rst_v[0] = 1'b0; step(1);
        chk("mid_reset", 0, int'(phase_o[0]) * 1000 + int'(hp1_o[0]) * 100 + int'(hp2_o[0]) * 10 + int'(win_o[0]), 550);
        chk("mid_reset_fen", 0, int'(fen_o[0]), 0);
        rst_v[0] = 1'b1; step(1);

        start_v[1] = 1'b1; step(1);
        start_v[1] = 1'b0; step(4);
        chk("b_fight", 1, int'(phase_o[1]) * 10 + int'(tl_o[1]), 23);
        p2_v[1] = 2'b11; step(1);
        chk("b_hit2", 1, int'(hit2_o[1]) * 10 + int'(hp1_o[1]), 14);
        p2_v[1] = 2'b00; step(5);
        chk("b_time_zero", 1, int'(phase_o[1]) * 10 + int'(tl_o[1]), 20);
        step(1);
        chk("b_timeout", 1, int'(phase_o[1]) * 100 + int'(win_o[1]) * 10 + int'(fen_o[1]), 320);

        start_v[1] = 1'b1; step(1);
        chk("b_reload", 1, int'(hp1_o[1]) * 10 + int'(win_o[1]), 50);
        start_v[1] = 1'b0; step(4);
        step(6);
        chk("b_last_fight", 1, int'(phase_o[1]), 2);
        step(1);
        chk("b_draw", 1, int'(phase_o[1]) * 10 + int'(win_o[1]), 33);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
